// File: rtl/warp_sched_pkg.sv
// Shared types and default constants for the warp issue scheduler.
// Imported by the scheduler top and its rotating priority finder.
package warp_sched_pkg;

  typedef enum logic {
    SCHED_LRR  = 1'b0,
    SCHED_GTRR = 1'b1
  } sched_mode_e;

  localparam int unsigned DEFAULT_NUM_WARPS    = 32;
  localparam int unsigned DEFAULT_AGE_W        = 4;
  localparam int unsigned DEFAULT_STARVE_LIMIT = 12;

  // Warp ID type at the default size; parametrised modules redeclare their own.
  typedef logic [$clog2(DEFAULT_NUM_WARPS)-1:0] default_wid_t;

  // Successor of a warp index, wrapping at the configured warp count.
  function automatic int unsigned wrap_next(input int unsigned idx, input int unsigned n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/warp_issue_scheduler_rr_find_first.sv
// Rotating priority finder: first set request at or above start, wrapping
// modulo N. Purely combinational.
module rr_find_first
  import warp_sched_pkg::*;
#(
  parameter int unsigned N     = DEFAULT_NUM_WARPS,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic             hi_found;
  logic             lo_found;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  // Descending scan so the last write leaves the lowest index in each half:
  // the upper half [start, N) has priority over the wrapped half [0, start).
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (req[i-1]) begin
        if ((i - 1) >= 32'(start)) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i - 1);
        end else begin
          lo_found = 1'b1;
          lo_idx   = IDX_W'(i - 1);
        end
      end
    end
  end

  always_comb begin
    found = hi_found | lo_found;
    idx   = hi_found ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/warp_issue_scheduler.sv
// Warp issue scheduler: LRR or GTRR selection with starvation override,
// driving a registered valid/ready issue port.
module warp_issue_scheduler
  import warp_sched_pkg::*;
#(
  parameter int unsigned NUM_WARPS    = DEFAULT_NUM_WARPS,
  parameter int unsigned WID_W        = $clog2(NUM_WARPS),
  parameter int unsigned AGE_W        = DEFAULT_AGE_W,
  parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_WARPS-1:0] warp_ready,
  input  logic [NUM_WARPS-1:0] warp_stalled,
  input  logic                 sched_mode,
  output logic                 issue_valid,
  output logic [WID_W-1:0]     issue_warp,
  input  logic                 issue_ready,
  output logic                 starve_hit
);

  typedef logic [WID_W-1:0] wid_t;
  typedef logic [AGE_W-1:0] age_t;

  localparam age_t AGE_LIMIT = AGE_W'(STARVE_LIMIT);
  localparam wid_t LAST_WARP = WID_W'(NUM_WARPS - 1);

  logic [NUM_WARPS-1:0] eligible;
  logic [NUM_WARPS-1:0] starving;
  age_t                 age [NUM_WARPS];
  wid_t                 rr_ptr;
  wid_t                 greedy_id;
  logic                 greedy_valid;
  sched_mode_e          mode;

  logic                 sel_cycle;
  logic                 starve_found;
  wid_t                 starve_idx;
  logic                 elig_found;
  wid_t                 elig_idx;
  logic                 load;
  logic                 load_starve;
  wid_t                 load_warp;

  always_comb begin
    eligible  = warp_ready & ~warp_stalled;
    sel_cycle = !issue_valid || issue_ready;
    mode      = sched_mode_e'(sched_mode);
    starving  = '0;
    for (int unsigned i = 0; i < NUM_WARPS; i++) begin
      starving[i] = eligible[i] && (age[i] == AGE_LIMIT);
    end
  end

  rr_find_first #(
    .N     (NUM_WARPS),
    .IDX_W (WID_W)
  ) u_starve_find (
    .req   (starving),
    .start (rr_ptr),
    .found (starve_found),
    .idx   (starve_idx)
  );

  rr_find_first #(
    .N     (NUM_WARPS),
    .IDX_W (WID_W)
  ) u_elig_find (
    .req   (eligible),
    .start (rr_ptr),
    .found (elig_found),
    .idx   (elig_idx)
  );

  // Starvation beats greedy, greedy beats round-robin.
  always_comb begin
    load        = 1'b0;
    load_starve = 1'b0;
    load_warp   = '0;
    if (sel_cycle) begin
      if (starve_found) begin
        load        = 1'b1;
        load_starve = 1'b1;
        load_warp   = starve_idx;
      end else if (mode == SCHED_GTRR && greedy_valid && eligible[greedy_id]) begin
        load      = 1'b1;
        load_warp = greedy_id;
      end else if (elig_found) begin
        load      = 1'b1;
        load_warp = elig_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      issue_valid  <= 1'b0;
      issue_warp   <= '0;
      starve_hit   <= 1'b0;
      rr_ptr       <= '0;
      greedy_id    <= '0;
      greedy_valid <= 1'b0;
    end else if (sel_cycle) begin
      if (load) begin
        issue_valid  <= 1'b1;
        issue_warp   <= load_warp;
        starve_hit   <= load_starve;
        rr_ptr       <= (load_warp == LAST_WARP) ? '0 : load_warp + 1'b1;
        greedy_id    <= load_warp;
        greedy_valid <= 1'b1;
      end else begin
        issue_valid  <= 1'b0;
        starve_hit   <= 1'b0;
        greedy_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_WARPS; i++) begin
      if (reset || !eligible[i] || (load && load_warp == WID_W'(i))) begin
        age[i] <= '0;
      end else if (age[i] != AGE_LIMIT) begin
        age[i] <= age[i] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_warp_issue_scheduler.sv
// Randomised and directed bench for warp_issue_scheduler (6 warps, limit 4)
// checked against a behavioural model of the selection rules.
module tb_warp_issue_scheduler;

  localparam int N     = 6;
  localparam int W     = 3;
  localparam int LIMIT = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] warp_ready;
  logic [N-1:0] warp_stalled;
  logic         sched_mode;
  logic         issue_valid;
  logic [W-1:0] issue_warp;
  logic         issue_ready;
  logic         starve_hit;

  int checks = 0;
  int errors = 0;

  int m_age [N];
  bit m_valid, m_starve, m_gv;
  int m_warp, m_rr, m_g;

  always #5 clk = ~clk;

  warp_issue_scheduler #(
    .NUM_WARPS    (N),
    .WID_W        (W),
    .AGE_W        (3),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .warp_ready   (warp_ready),
    .warp_stalled (warp_stalled),
    .sched_mode   (sched_mode),
    .issue_valid  (issue_valid),
    .issue_warp   (issue_warp),
    .issue_ready  (issue_ready),
    .starve_hit   (starve_hit)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit el [N];
    bit found;
    int s;
    bit st;
    if (reset) begin
      m_valid = 0; m_warp = 0; m_starve = 0; m_rr = 0; m_g = 0; m_gv = 0;
      for (int i = 0; i < N; i++) m_age[i] = 0;
      return;
    end
    for (int i = 0; i < N; i++) el[i] = warp_ready[i] && !warp_stalled[i];
    found = 0; s = -1; st = 0;
    if (!m_valid || issue_ready) begin
      for (int k = 0; k < N && !found; k++)
        if (el[(m_rr + k) % N] && m_age[(m_rr + k) % N] == LIMIT) begin
          found = 1; s = (m_rr + k) % N; st = 1;
        end
      if (!found && sched_mode && m_gv && el[m_g]) begin
        found = 1; s = m_g;
      end
      for (int k = 0; k < N && !found; k++)
        if (el[(m_rr + k) % N]) begin
          found = 1; s = (m_rr + k) % N;
        end
      if (found) begin
        m_valid = 1; m_warp = s; m_starve = st; m_rr = (s + 1) % N; m_g = s; m_gv = 1;
      end else begin
        m_valid = 0; m_starve = 0; m_gv = 0;
      end
    end
    for (int i = 0; i < N; i++)
      m_age[i] = (!el[i] || i == s) ? 0 : ((m_age[i] + 1 > LIMIT) ? LIMIT : m_age[i] + 1);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_eq("issue_valid", issue_valid, m_valid);
    check_eq("issue_warp", issue_warp, m_warp);
    check_eq("starve_hit", starve_hit, m_starve);
    check_eq("warp_in_range", issue_warp < N, 1);
  endtask

  task automatic drive(input logic [N-1:0] rdy, input logic [N-1:0] stl,
                       input logic mode, input logic acc);
    warp_ready = rdy; warp_stalled = stl; sched_mode = mode; issue_ready = acc;
  endtask

  initial begin
    reset = 1'b1;
    drive('0, '0, 1'b0, 1'b0);
    #1;
    tick(); tick();
    check_eq("reset_valid", issue_valid, 0);
    check_eq("reset_warp", issue_warp, 0);
    reset = 1'b0;

    // LRR fairness, all eligible, wraps through 5 back to 0
    drive('1, '0, 1'b0, 1'b1);
    for (int i = 0; i < N + 2; i++) tick();

    // GTRR sticks to warp 2, then falls over to 5 when 2 stalls
    drive(6'b100100, '0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    drive(6'b100100, 6'b000100, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) tick();

    // Starvation: greedy locked on 1, warp 3 joins and must eventually win
    drive(6'b000010, '0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    drive(6'b001010, '0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) tick();

    // Backpressure with shifting eligibility, then release
    for (int i = 0; i < 5; i++) begin
      drive(N'($urandom), N'($urandom), 1'($urandom), 1'b0);
      tick();
    end
    drive('1, '0, 1'b0, 1'b1);
    tick(); tick();

    // Single warp at the top index, then at 0, then nothing
    drive(6'b100000, '0, 1'b0, 1'b1);
    tick(); tick();
    drive(6'b000001, '0, 1'b0, 1'b1);
    tick(); tick();
    drive('0, '0, 1'b0, 1'b1);
    tick(); tick();

    // Reset while a selection is held
    drive('1, '0, 1'b0, 1'b0);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive('1, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick();

    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive(N'($urandom), N'($urandom) & N'($urandom), 1'($urandom),
            ($urandom_range(0, 3) != 0));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
